util_1553_manchester_rx: RTL and testbench
==========================================

Name: util_1553_manchester_rx

Overview:
- MIL-STD-1553 Manchester II receive decoder. Sits between the PMOD 1553 transceiver receive pins (differential pair from the bus) and the UART bridge logic, acting as the receive end of the encoder.
- Detects the command/status or data sync, decodes 16 data bits plus odd parity, and presents each word on an AXI-stream master port with type and error flags.

Parameters:
- CLOCK_SPEED, 100000000, aclk frequency in Hz.
- BIT_RATE, 1000000, bus bit rate in Hz. T = CLOCK_SPEED/BIT_RATE; T must be even, a multiple of 4, and at least 16.
- SYNC_TOL, 10, allowed +/- deviation in cycles on each 1.5T sync half.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- rx_pos  in  1  bus receive positive leg, asynchronous.
- rx_neg  in  1  bus receive negative leg, asynchronous.
- m_axis_tdata  out  16  decoded word, MSB first on bus = bit 15.
- m_axis_tuser  out  3  [0]=1 command/status sync, 0 data sync; [1] parity error; [2] Manchester/coding error.
- m_axis_tvalid  out  1  word available.
- m_axis_tready  in  1  sink accepts.
- rx_busy  out  1  high from sync detect until word emitted/aborted.
- overrun  out  1  one-cycle pulse when a completed word is dropped.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, synchronizers cleared. Reset mid-word aborts the word with no output.
- Input: rx_pos and rx_neg each pass through a 2-FF synchronizer, giving 2 cycles latency. Line level = rx_pos when rx_pos != rx_neg; pos == neg is invalid/idle.
- IDLE:
  - A valid level starts run counter rc=1, and rc increments while the level is held.
  - On a level change: if rc is within [1.5T-SYNC_TOL, 1.5T+SYNC_TOL], record sync type (first half high = command/status) and go to SYNC_B with cnt=0, rx_busy=1.
  - Otherwise restart the run on the new level.
  - Invalid line resets rc to 0.
- SYNC_B:
  - Line must hold the opposite level, and must remain valid, while cnt < 1.5T-SYNC_TOL. A change or invalid line aborts to IDLE, rx_busy=0.
  - At cnt = 1.5T-1 go to DATA with bit index bi=0, phase ph=0.
- DATA (bi 0..15 data, 16 parity):
  - Sample s1 at ph=T/4 and s2 at ph=3T/4. Bit value = s1.
  - s1 == s2, or invalid line at either sample, sets the coding-error flag; decoding continues.
  - Resync: a level transition seen with ph in [T/4+1, 3T/4-1] forces ph to T/2 on the next cycle.
  - At ph=T-1: ph=0, bi++. After bi=16 completes, go to OUTPUT.
- OUTPUT (1 cycle):
  - Parity error = (count of ones in 16 data + parity bit) is even.
  - If m_axis_tvalid=0, or it is being accepted this cycle (tvalid & tready), load tdata/tuser and set tvalid=1.
  - Otherwise drop the word and pulse overrun.
  - rx_busy=0, return to IDLE.
- Output register: one entry. tvalid stays high with tdata/tuser stable until tready. tvalid clears on the accept cycle unless reloaded in that same cycle.
- Timing: tvalid rises the cycle after the parity bit's ph=T-1 cycle. Total from sync mid-transition (synchronized) to tvalid = 1.5T + 17T + 1 cycles.
- Back-to-back words with no gap: the IDLE run measurement starts on the first cycle after OUTPUT.

Test Plan:
- T=100. Command sync, 0xA5A5, parity 1 -> tdata=0xA5A5, tuser=3'b001, tvalid at sync-mid+1851 cycles (after the 2-cycle synchronizer), held until tready.
- Data sync, 0x0000, parity 1 -> tdata=0x0000, tuser=3'b000. Data sync, 0xFFFF, parity 0 -> tdata=0xFFFF, tuser=3'b010.
- First sync half 120 cycles -> no tvalid, rx_busy returns 0. A valid 0x1234 command word immediately after -> decoded correctly.
- Bit 5 sent with no mid-bit transition (held high a full bit) -> word emitted with tuser[2]=1.
- tready=0, two back-to-back words -> first held unchanged, second dropped, overrun high exactly 1 cycle. With tready=1 on the OUTPUT cycle, the second word is loaded instead.
- Transmitter bit period 103 cycles (+3%), word 0x8001 -> decoded correctly via resync. rst asserted at bit 8 -> no output, all outputs 0, next word decoded correctly.

Source files
------------

// File: rtl/util_1553_manchester_rx.sv
// MIL-STD-1553 Manchester II receive decoder: sync detection, 16 data bits plus odd parity,
// one-entry AXI-stream output with sync-type / parity-error / coding-error flags.
module util_1553_manchester_rx #(
    parameter int unsigned CLOCK_SPEED = 100000000,
    parameter int unsigned BIT_RATE    = 1000000,
    parameter int unsigned SYNC_TOL    = 10
) (
    input  logic        aclk,
    input  logic        rst,
    input  logic        rx_pos,
    input  logic        rx_neg,
    output logic [15:0] m_axis_tdata,
    output logic [2:0]  m_axis_tuser,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        rx_busy,
    output logic        overrun
);
    localparam int unsigned T  = CLOCK_SPEED / BIT_RATE;
    localparam int unsigned CW = $clog2(2 * T + SYNC_TOL + 2);

    localparam logic [CW-1:0] SYNC_LO  = CW'(3 * T / 2 - SYNC_TOL);
    localparam logic [CW-1:0] SYNC_HI  = CW'(3 * T / 2 + SYNC_TOL);
    localparam logic [CW-1:0] SYNC_END = CW'(3 * T / 2 - 1);
    localparam logic [CW-1:0] PH_Q1    = CW'(T / 4);
    localparam logic [CW-1:0] PH_HALF  = CW'(T / 2);
    localparam logic [CW-1:0] PH_Q3    = CW'(3 * T / 4);
    localparam logic [CW-1:0] PH_LAST  = CW'(T - 1);

    typedef enum logic [1:0] {IDLE, SYNC_B, DATA} state_t;

    state_t        state_q, state_d;
    logic          pos_m_q, pos_s_q, neg_m_q, neg_s_q;
    logic          prev_lvl_q, prev_valid_q;
    logic [CW-1:0] rc_q, rc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    bi_q, bi_d;
    logic [16:0]   shreg_q, shreg_d;
    logic          s1_q, s1_d, s1_bad_q, s1_bad_d;
    logic          cerr_q, cerr_d;
    logic          cmd_q, cmd_d;
    logic [15:0]   tdata_q, tdata_d;
    logic [2:0]    tuser_q, tuser_d;
    logic          tvalid_q, tvalid_d;
    logic          overrun_q, overrun_d;
    logic          line_valid, line_lvl, transition, emit;

    assign line_valid = pos_s_q ^ neg_s_q;
    assign line_lvl   = pos_s_q;
    assign transition = line_valid & prev_valid_q & (line_lvl != prev_lvl_q);

    always_comb begin
        state_d   = state_q;
        rc_d      = '0;
        cnt_d     = cnt_q;
        bi_d      = bi_q;
        shreg_d   = shreg_q;
        s1_d      = s1_q;
        s1_bad_d  = s1_bad_q;
        cerr_d    = cerr_q;
        cmd_d     = cmd_q;
        emit      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!line_valid) begin
                    rc_d = '0;
                end else if (rc_q == '0) begin
                    rc_d = CW'(1);
                end else if (line_lvl != prev_lvl_q) begin
                    if (rc_q >= SYNC_LO && rc_q <= SYNC_HI) begin
                        state_d = SYNC_B;
                        cnt_d   = '0;
                        cmd_d   = prev_lvl_q;
                    end else begin
                        rc_d = CW'(1);
                    end
                end else begin
                    rc_d = (rc_q == '1) ? rc_q : rc_q + 1'b1;
                end
            end
            SYNC_B: begin
                if (cnt_q < SYNC_LO && (!line_valid || line_lvl == cmd_q)) begin
                    state_d = IDLE;
                end else if (cnt_q == SYNC_END) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    bi_d    = '0;
                    cerr_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == PH_Q1) begin
                    s1_d     = line_lvl;
                    s1_bad_d = !line_valid;
                end
                if (cnt_q == PH_Q3) begin
                    shreg_d = {shreg_q[15:0], s1_q};
                    if (!line_valid || s1_bad_q || line_lvl == s1_q) cerr_d = 1'b1;
                end
                if (transition && cnt_q > PH_Q1 && cnt_q < PH_Q3) cnt_d = PH_HALF;
                // The word is emitted on the parity bit's last phase cycle, so tvalid rises
                // the next cycle and the following sync run is measured from its true start.
                if (cnt_q == PH_LAST) begin
                    cnt_d = '0;
                    bi_d  = bi_q + 1'b1;
                    if (bi_q == 5'd16) begin
                        emit    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        tvalid_d  = tvalid_q & ~m_axis_tready;
        tdata_d   = tdata_q;
        tuser_d   = tuser_q;
        overrun_d = 1'b0;
        if (emit) begin
            if (!tvalid_q || m_axis_tready) begin
                tvalid_d = 1'b1;
                tdata_d  = shreg_q[16:1];
                tuser_d  = {cerr_q, ~^shreg_q, cmd_q};
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            pos_m_q      <= 1'b0;
            pos_s_q      <= 1'b0;
            neg_m_q      <= 1'b0;
            neg_s_q      <= 1'b0;
            prev_lvl_q   <= 1'b0;
            prev_valid_q <= 1'b0;
            state_q      <= IDLE;
            rc_q         <= '0;
            cnt_q        <= '0;
            bi_q         <= '0;
            shreg_q      <= '0;
            s1_q         <= 1'b0;
            s1_bad_q     <= 1'b0;
            cerr_q       <= 1'b0;
            cmd_q        <= 1'b0;
            tdata_q      <= '0;
            tuser_q      <= '0;
            tvalid_q     <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            pos_m_q      <= rx_pos;
            pos_s_q      <= pos_m_q;
            neg_m_q      <= rx_neg;
            neg_s_q      <= neg_m_q;
            prev_lvl_q   <= line_lvl;
            prev_valid_q <= line_valid;
            state_q      <= state_d;
            rc_q         <= rc_d;
            cnt_q        <= cnt_d;
            bi_q         <= bi_d;
            shreg_q      <= shreg_d;
            s1_q         <= s1_d;
            s1_bad_q     <= s1_bad_d;
            cerr_q       <= cerr_d;
            cmd_q        <= cmd_d;
            tdata_q      <= tdata_d;
            tuser_q      <= tuser_d;
            tvalid_q     <= tvalid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tvalid = tvalid_q;
    assign rx_busy       = (state_q != IDLE);
    assign overrun       = overrun_q;
endmodule

// File: tb/tb_util_1553_manchester_rx.sv
// Directed bench for util_1553_manchester_rx at T=100 cycles per bit; expected words,
// flags and latencies are worked out by hand from the transmitted waveforms.
`timescale 1ns/1ps
module tb_util_1553_manchester_rx;
    logic        aclk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_pos = 1'b0;
    logic        rx_neg = 1'b0;
    logic        m_axis_tready = 1'b0;
    logic [15:0] m_axis_tdata;
    logic [2:0]  m_axis_tuser;
    logic        m_axis_tvalid;
    logic        rx_busy;
    logic        overrun;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cyc = 0;
    int unsigned mid_cyc = 0;
    int unsigned rise_cyc = 0;
    int unsigned ovr_cyc = 0;
    int unsigned busy_cyc = 0;
    logic        tv_prev = 1'b0;

    util_1553_manchester_rx #(
        .CLOCK_SPEED(100000000),
        .BIT_RATE   (1000000),
        .SYNC_TOL   (10)
    ) dut (
        .aclk         (aclk),
        .rst          (rst),
        .rx_pos       (rx_pos),
        .rx_neg       (rx_neg),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tuser (m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .rx_busy      (rx_busy),
        .overrun      (overrun)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    always @(negedge aclk) begin
        if (m_axis_tvalid && !tv_prev) rise_cyc <= cyc;
        tv_prev <= m_axis_tvalid;
        if (overrun) ovr_cyc <= ovr_cyc + 1;
        if (rx_busy) busy_cyc <= busy_cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic p, input logic n, input int unsigned cycles);
        rx_pos = p;
        rx_neg = n;
        repeat (cycles) @(negedge aclk);
    endtask

    task automatic lvl(input logic l, input int unsigned cycles);
        drive(l, ~l, cycles);
    endtask

    task automatic idle(input int unsigned cycles);
        drive(1'b0, 1'b0, cycles);
    endtask

    // Bit 1 is high-then-low; bad_bit (if >= 0) is held high for the whole bit.
    task automatic send_word(input logic cmd, input logic [15:0] data, input logic par,
                             input int unsigned per, input int bad_bit, input int unsigned h1);
        logic [16:0] bits;
        bits = {data, par};
        lvl(cmd, h1);
        mid_cyc = cyc;
        lvl(~cmd, (3 * per + 1) / 2);
        for (int i = 0; i < 17; i++) begin
            if (i == bad_bit) begin
                lvl(1'b1, per);
            end else begin
                lvl(bits[16-i], per / 2);
                lvl(~bits[16-i], per - per / 2);
            end
        end
    endtask

    task automatic wait_valid(input string tag, input int unsigned max_cyc);
        int unsigned i;
        i = 0;
        while (!m_axis_tvalid && i < max_cyc) begin
            @(negedge aclk);
            i++;
        end
        check({tag, "_tvalid"}, m_axis_tvalid, 1);
    endtask

    task automatic accept(input string tag);
        m_axis_tready = 1'b1;
        @(negedge aclk);
        m_axis_tready = 1'b0;
        @(negedge aclk);
        check({tag, "_cleared"}, m_axis_tvalid, 0);
    endtask

    task automatic expect_word(input string tag, input logic [15:0] data, input logic [2:0] user);
        wait_valid(tag, 20);
        check({tag, "_tdata"}, m_axis_tdata, data);
        check({tag, "_tuser"}, m_axis_tuser, user);
        accept(tag);
    endtask

    initial begin
        int unsigned snap;
        idle(5);
        rst = 1'b0;
        idle(3);
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_tuser", m_axis_tuser, 0);
        check("rst_busy", rx_busy, 0);
        check("rst_overrun", overrun, 0);

        // Command word; tvalid 1851 cycles after the synchronized mid-sync edge (+2 sync).
        send_word(1'b1, 16'hA5A5, 1'b1, 100, -1, 150);
        idle(5);
        check("a5_latency", rise_cyc - mid_cyc, 1853);
        check("a5_tvalid", m_axis_tvalid, 1);
        check("a5_tdata", m_axis_tdata, 16'hA5A5);
        check("a5_tuser", m_axis_tuser, 3'b001);
        check("a5_busy", rx_busy, 0);
        idle(40);
        check("a5_held_tvalid", m_axis_tvalid, 1);
        check("a5_held_tdata", m_axis_tdata, 16'hA5A5);
        accept("a5");

        send_word(1'b0, 16'h0000, 1'b1, 100, -1, 150);
        idle(5);
        expect_word("d0000", 16'h0000, 3'b000);
        send_word(1'b0, 16'hFFFF, 1'b0, 100, -1, 150);
        idle(5);
        expect_word("dffff_perr", 16'hFFFF, 3'b010);

        // Out-of-window first half (120) rejected; valid word follows immediately.
        snap = busy_cyc;
        lvl(1'b1, 120);
        lvl(1'b0, 120);
        check("badsync_tvalid", m_axis_tvalid, 0);
        check("badsync_busy_cycles", busy_cyc - snap, 0);
        send_word(1'b1, 16'h1234, 1'b0, 100, -1, 150);
        idle(5);
        expect_word("c1234", 16'h1234, 3'b001);

        // Second sync half broken early: busy rises then drops, no word.
        lvl(1'b1, 150);
        lvl(1'b0, 60);
        check("syncb_busy", rx_busy, 1);
        idle(20);
        check("syncb_abort_busy", rx_busy, 0);
        check("syncb_abort_tvalid", m_axis_tvalid, 0);

        // Bit 5 held high: decodes as 1 (0x0400), coding and parity errors.
        send_word(1'b1, 16'h0000, 1'b1, 100, 5, 150);
        idle(5);
        expect_word("cerr", 16'h0400, 3'b111);

        // Back-to-back with tready low: first held, second dropped, one overrun cycle.
        snap = ovr_cyc;
        send_word(1'b0, 16'h00FF, 1'b1, 100, -1, 150);
        send_word(1'b1, 16'h0F0F, 1'b1, 100, -1, 150);
        idle(10);
        check("ovr_tvalid", m_axis_tvalid, 1);
        check("ovr_tdata", m_axis_tdata, 16'h00FF);
        check("ovr_tuser", m_axis_tuser, 3'b000);
        check("ovr_pulse_cycles", ovr_cyc - snap, 1);
        accept("ovr");

        // Back-to-back with tready high on the second word's emit cycle: it replaces the first.
        snap = ovr_cyc;
        send_word(1'b0, 16'h3C00, 1'b1, 100, -1, 150);
        send_word(1'b1, 16'h0001, 1'b0, 100, -1, 150);
        idle(2);
        check("reload_before_tdata", m_axis_tdata, 16'h3C00);
        m_axis_tready = 1'b1;
        idle(1);
        m_axis_tready = 1'b0;
        check("reload_tvalid", m_axis_tvalid, 1);
        check("reload_tdata", m_axis_tdata, 16'h0001);
        check("reload_tuser", m_axis_tuser, 3'b001);
        check("reload_no_overrun", ovr_cyc - snap, 0);
        accept("reload");

        // Slow transmitter (103-cycle bits), left pending so reset must clear it.
        send_word(1'b1, 16'h8001, 1'b1, 103, -1, 155);
        idle(5);
        wait_valid("slow", 20);
        check("slow_tdata", m_axis_tdata, 16'h8001);
        check("slow_tuser", m_axis_tuser, 3'b001);

        fork
            send_word(1'b1, 16'h5555, 1'b1, 100, -1, 150);
            begin
                repeat (1110) @(negedge aclk);
                rst = 1'b1;
                repeat (2) @(negedge aclk);
                rst = 1'b0;
                @(negedge aclk);
                check("midrst_tvalid", m_axis_tvalid, 0);
                check("midrst_tdata", m_axis_tdata, 0);
                check("midrst_tuser", m_axis_tuser, 0);
                check("midrst_busy", rx_busy, 0);
                check("midrst_overrun", overrun, 0);
            end
        join
        idle(20);
        check("midrst_no_word", m_axis_tvalid, 0);
        check("midrst_idle_busy", rx_busy, 0);
        send_word(1'b0, 16'hC3C3, 1'b1, 100, -1, 150);
        idle(5);
        expect_word("post_rst", 16'hC3C3, 3'b000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
